// File: rtl/coord_bcd_latch_pkg.sv
// Shared definitions for the coordinate BCD latch: FSM states, digit
// geometry, text-display character codes and the double-dabble nibble fix-up.
package coord_bcd_latch_pkg;

    localparam int BCD_W  = 4;
    localparam int DIGITS = 3;

    // Character codes shared with the letter generator users.
    localparam logic [7:0] CHAR_X     = 8'h58;
    localparam logic [7:0] CHAR_Y     = 8'h59;
    localparam logic [7:0] CHAR_Z     = 8'h5A;
    localparam logic [7:0] CHAR_COLON = 8'h3A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    // {hundreds, tens, ones}
    typedef logic [BCD_W*DIGITS-1:0] bcd3_t;

    // Add-3 correction applied to a BCD nibble before each shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/coord_bcd_latch_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// One load cycle followed by eight shift cycles; done is high during the
// ninth cycle and bcd then shows the value after the final shift, so the
// caller can capture the result on that edge.
module coord_bcd_latch_bin2bcd_seq
    import coord_bcd_latch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output bcd3_t      bcd
);

    logic [19:0] sh_q;
    logic [3:0]  cnt_q;
    logic [19:0] adj;
    logic [19:0] shifted;

    // Correct every BCD nibble, then shift {bcd, bin} left by one.
    always_comb begin
        adj          = sh_q;
        adj[19:16]   = dd_adjust(sh_q[19:16]);
        adj[15:12]   = dd_adjust(sh_q[15:12]);
        adj[11:8]    = dd_adjust(sh_q[11:8]);
        shifted      = {adj[18:0], 1'b0};
    end

    // Load on start, then count down through eight shift cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            sh_q  <= {12'd0, bin};
            cnt_q <= 4'd8;
            busy  <= 1'b1;
        end else if (busy) begin
            sh_q  <= shifted;
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1)
                busy <= 1'b0;
        end
    end

    assign done = busy && (cnt_q == 4'd1);
    assign bcd  = shifted[19:8];

endmodule

// File: rtl/coord_bcd_latch.sv
// Converts X/Y/Z coordinates to BCD digits with one shared converter and
// presents them to the text display only on a frame boundary (or right
// after the result is ready when frame-locking is disabled).
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | ready=1; a load latches val_x/y/z and starts conversion
//   ST_CONV  | converter time-shared over channels 0..2 (9 cycles each)
//   ST_STORE | all nine digits written to the shadow bank, pending set
//
// DATA_W is fixed at 8 (three digits, max 255).
module coord_bcd_latch
    import coord_bcd_latch_pkg::*;
#(
    parameter logic COMMIT_ON_FRAME = 1'b1,
    parameter int   DATA_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] val_x,
    input  logic [DATA_W-1:0] val_y,
    input  logic [DATA_W-1:0] val_z,
    input  logic              load,
    input  logic              frame_start,
    output logic              ready,
    output logic [3:0]        x_hund,
    output logic [3:0]        x_tens,
    output logic [3:0]        x_ones,
    output logic [3:0]        y_hund,
    output logic [3:0]        y_tens,
    output logic [3:0]        y_ones,
    output logic [3:0]        z_hund,
    output logic [3:0]        z_tens,
    output logic [3:0]        z_ones,
    output logic              updated
);

    state_t            state_q, state_d;
    logic [1:0]        ch_q;
    logic [DATA_W-1:0] wx_q, wy_q, wz_q;
    bcd3_t             res_x_q, res_y_q, res_z_q;
    bcd3_t             sh_x_q, sh_y_q, sh_z_q;
    bcd3_t             out_x_q, out_y_q, out_z_q;
    logic              pending_q;
    logic              updated_q;

    logic              accept;
    logic              conv_start;
    logic              res_capture;
    logic              store;
    logic              commit;
    logic [7:0]        conv_bin;
    logic              conv_busy;
    logic              conv_done;
    bcd3_t             conv_bcd;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        accept      = 1'b0;
        conv_start  = 1'b0;
        res_capture = 1'b0;
        store       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (load) begin
                    accept  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                conv_start = !conv_busy;
                if (conv_done) begin
                    res_capture = 1'b1;
                    if (ch_q == 2'd2)
                        state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                store   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working inputs are captured at accept so val_* may change afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q <= 2'd0;
            wx_q <= '0;
            wy_q <= '0;
            wz_q <= '0;
        end else if (accept) begin
            ch_q <= 2'd0;
            wx_q <= val_x;
            wy_q <= val_y;
            wz_q <= val_z;
        end else if (res_capture) begin
            ch_q <= ch_q + 2'd1;
        end
    end

    // Feed the channel currently being converted.
    always_comb begin
        conv_bin = wx_q;
        unique case (ch_q)
            2'd1:    conv_bin = wy_q;
            2'd2:    conv_bin = wz_q;
            default: conv_bin = wx_q;
        endcase
    end

    coord_bcd_latch_bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Collect each channel's digits as the converter finishes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_x_q <= '0;
            res_y_q <= '0;
            res_z_q <= '0;
        end else if (res_capture) begin
            unique case (ch_q)
                2'd0:    res_x_q <= conv_bcd;
                2'd1:    res_y_q <= conv_bcd;
                default: res_z_q <= conv_bcd;
            endcase
        end
    end

    // A store on the same edge defers the commit so the new shadow is never
    // split from the one being displayed.
    assign commit = pending_q && !store && (COMMIT_ON_FRAME ? frame_start : 1'b1);

    // Shadow bank, pending flag and atomic commit to the display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_z_q    <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_z_q   <= '0;
            pending_q <= 1'b0;
            updated_q <= 1'b0;
        end else begin
            updated_q <= commit;
            if (store) begin
                sh_x_q    <= res_x_q;
                sh_y_q    <= res_y_q;
                sh_z_q    <= res_z_q;
                pending_q <= 1'b1;
            end else if (commit) begin
                out_x_q   <= sh_x_q;
                out_y_q   <= sh_y_q;
                out_z_q   <= sh_z_q;
                pending_q <= 1'b0;
            end
        end
    end

    assign x_hund  = out_x_q[11:8];
    assign x_tens  = out_x_q[7:4];
    assign x_ones  = out_x_q[3:0];
    assign y_hund  = out_y_q[11:8];
    assign y_tens  = out_y_q[7:4];
    assign y_ones  = out_y_q[3:0];
    assign z_hund  = out_z_q[11:8];
    assign z_tens  = out_z_q[7:4];
    assign z_ones  = out_z_q[3:0];
    assign updated = updated_q;

endmodule
